peripheral_cs_initiator: RTL and testbench

//  Control-system-side bus initiator for the peripheral register block: drives req/rw/add/data on the
//  cs port and captures the registered read data. Accepts single read/write/poll commands from the host

---
 rtl/peripheral_cs_initiator.sv | 126 ++++++++++++
 tb/tb_peripheral_cs_initiator.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/peripheral_cs_initiator.sv
// Bus initiator for the peripheral register block: single read/write/poll commands in,
// one-cycle req pulses out on the cs port, registered read/poll results back over valid/ready.
module peripheral_cs_initiator #(
    parameter int unsigned READ_LATENCY = 1,
    parameter int unsigned POLL_GAP     = 4,
    parameter int unsigned POLL_MAX     = 1024
) (
    input  logic        clock_i,
    input  logic        reset_i,
    input  logic        cmd_valid_i,
    output logic        cmd_ready_o,
    input  logic        cmd_rw_i,
    input  logic        cmd_poll_i,
    input  logic [26:0] cmd_add_i,
    input  logic [31:0] cmd_data_i,
    input  logic [31:0] cmd_mask_i,
    output logic        req_o,
    output logic        rw_o,
    output logic [26:0] add_o,
    output logic [31:0] data_o,
    input  logic [31:0] data_i,
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [31:0] rsp_data_o,
    output logic        rsp_timeout_o,
    output logic        busy_o
);
    localparam int unsigned CNT_MAX = (READ_LATENCY > POLL_GAP) ? READ_LATENCY : POLL_GAP;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
    localparam int unsigned POLL_W  = $clog2(POLL_MAX + 1);

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP,
        GAP
    } state_t;

    state_t             state;
    state_t             state_next;
    logic               poll;
    logic [31:0]        mask;
    logic [CNT_W-1:0]   cnt;
    logic [POLL_W-1:0]  poll_cnt;
    logic               hit;
    logic               last_cycle;
    logic               poll_done;

    assign cmd_ready_o = (state == IDLE);

    // add_o/rw_o/data_o are loaded at accept and reused for every poll re-issue; data_o holds the match value.
    assign hit        = ((data_i ^ data_o) & mask) == '0;
    assign last_cycle = (cnt == CNT_W'(1));
    assign poll_done  = (poll_cnt == POLL_W'(POLL_MAX));

    always_comb begin
        state_next = state;
        case (state)
            IDLE:  if (cmd_valid_i) state_next = ISSUE;
            ISSUE: state_next = rw_o ? IDLE : WAIT;
            WAIT: begin
                if (last_cycle) begin
                    if (!poll || hit || poll_done) state_next = RESP;
                    else if (POLL_GAP == 0)        state_next = ISSUE;
                    else                           state_next = GAP;
                end
            end
            GAP:   if (cnt <= CNT_W'(1)) state_next = ISSUE;
            RESP:  if (rsp_ready_i) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state         <= IDLE;
            req_o         <= 1'b0;
            rw_o          <= 1'b0;
            add_o         <= '0;
            data_o        <= '0;
            rsp_valid_o   <= 1'b0;
            rsp_data_o    <= '0;
            rsp_timeout_o <= 1'b0;
            busy_o        <= 1'b0;
            poll          <= 1'b0;
            mask          <= '0;
            cnt           <= '0;
            poll_cnt      <= '0;
        end else begin
            state       <= state_next;
            req_o       <= (state_next == ISSUE);
            rsp_valid_o <= (state_next == RESP);
            busy_o      <= (state_next != IDLE);

            case (state)
                IDLE: begin
                    if (cmd_valid_i) begin
                        rw_o     <= cmd_rw_i & ~cmd_poll_i;
                        poll     <= cmd_poll_i;
                        add_o    <= cmd_add_i;
                        data_o   <= cmd_data_i;
                        mask     <= cmd_mask_i;
                        poll_cnt <= POLL_W'(1);
                    end
                end
                ISSUE: cnt <= CNT_W'(READ_LATENCY);
                WAIT: begin
                    if (last_cycle) begin
                        rsp_data_o <= data_i;
                        if (state_next == RESP) begin
                            rsp_timeout_o <= poll & ~hit;
                        end else begin
                            poll_cnt <= poll_cnt + POLL_W'(1);
                            cnt      <= CNT_W'(POLL_GAP);
                        end
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                GAP: cnt <= cnt - CNT_W'(1);
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_peripheral_cs_initiator.sv
// Directed bench for peripheral_cs_initiator: write, read, poll match/timeout, response stall, mid-op reset.
module tb_peripheral_cs_initiator;
    localparam logic [26:0] COMM_CONTROL   = 27'h000_0000;
    localparam logic [26:0] COMM_REGISTER1 = 27'h000_0014;
    localparam logic [26:0] COMM_CACHE0    = 27'h000_0100;

    logic        clock_i = 1'b0;
    logic        reset_i = 1'b1;
    logic        cmd_valid_i = 1'b0;
    logic        cmd_ready_o;
    logic        cmd_rw_i = 1'b0;
    logic        cmd_poll_i = 1'b0;
    logic [26:0] cmd_add_i = '0;
    logic [31:0] cmd_data_i = '0;
    logic [31:0] cmd_mask_i = '0;
    logic        req_o;
    logic        rw_o;
    logic [26:0] add_o;
    logic [31:0] data_o;
    logic [31:0] data_i;
    logic        rsp_valid_o;
    logic        rsp_ready_i = 1'b0;
    logic [31:0] rsp_data_o;
    logic        rsp_timeout_o;
    logic        busy_o;

    int passed = 0;
    int failed = 0;
    int total  = 0;

    // Peripheral model: read data depends on mode and on how many reads this command has issued.
    int          mode = 0;
    logic [31:0] reqs = '0;
    logic [31:0] base = '0;
    logic [31:0] cyc = '0;
    logic [31:0] last_req = '0;
    logic [31:0] last_gap = '0;
    logic        prev_req = 1'b0;
    logic        b2b = 1'b0;
    logic [31:0] nreads;

    assign nreads = reqs - base;
    assign data_i = (mode == 0) ? 32'hCAFE_F00D :
                    (mode == 1) ? ((nreads >= 32'd3) ? 32'hFFFF_FFF1 : 32'hFFFF_FFF0) :
                                  (32'hA5A5_0000 | nreads);

    peripheral_cs_initiator #(
        .READ_LATENCY(1),
        .POLL_GAP    (4),
        .POLL_MAX    (8)
    ) dut (
        .clock_i      (clock_i),
        .reset_i      (reset_i),
        .cmd_valid_i  (cmd_valid_i),
        .cmd_ready_o  (cmd_ready_o),
        .cmd_rw_i     (cmd_rw_i),
        .cmd_poll_i   (cmd_poll_i),
        .cmd_add_i    (cmd_add_i),
        .cmd_data_i   (cmd_data_i),
        .cmd_mask_i   (cmd_mask_i),
        .req_o        (req_o),
        .rw_o         (rw_o),
        .add_o        (add_o),
        .data_o       (data_o),
        .data_i       (data_i),
        .rsp_valid_o  (rsp_valid_o),
        .rsp_ready_i  (rsp_ready_i),
        .rsp_data_o   (rsp_data_o),
        .rsp_timeout_o(rsp_timeout_o),
        .busy_o       (busy_o)
    );

    always #5 clock_i = ~clock_i;

    always @(posedge clock_i) begin
        if (req_o) begin
            if (prev_req) b2b <= 1'b1;
            last_gap <= cyc - last_req;
            last_req <= cyc;
            reqs     <= reqs + 32'd1;
        end
        prev_req <= req_o;
        cyc      <= cyc + 32'd1;
    end

    task automatic step();
        @(posedge clock_i);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_req"},     {31'd0, req_o},         32'd0);
        check({tag, "_rw"},      {31'd0, rw_o},          32'd0);
        check({tag, "_add"},     {5'd0, add_o},          32'd0);
        check({tag, "_data"},    data_o,                 32'd0);
        check({tag, "_rvalid"},  {31'd0, rsp_valid_o},   32'd0);
        check({tag, "_rdata"},   rsp_data_o,             32'd0);
        check({tag, "_timeout"}, {31'd0, rsp_timeout_o}, 32'd0);
        check({tag, "_busy"},    {31'd0, busy_o},        32'd0);
        check({tag, "_ready"},   {31'd0, cmd_ready_o},   32'd1);
    endtask

    // Presents one command for one cycle; returns in the cycle after acceptance (the ISSUE cycle).
    task automatic send(input logic rw, input logic poll, input logic [26:0] add,
                        input logic [31:0] data, input logic [31:0] mask);
        base        = reqs;
        cmd_valid_i = 1'b1;
        cmd_rw_i    = rw;
        cmd_poll_i  = poll;
        cmd_add_i   = add;
        cmd_data_i  = data;
        cmd_mask_i  = mask;
        step();
        cmd_valid_i = 1'b0;
        cmd_rw_i    = 1'b0;
        cmd_poll_i  = 1'b0;
    endtask

    task automatic wait_rsp(output bit seen);
        seen = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (rsp_valid_o) begin
                seen = 1'b1;
                break;
            end
            step();
        end
    endtask

    task automatic handshake();
        rsp_ready_i = 1'b1;
        step();
        rsp_ready_i = 1'b0;
        check("hs_valid_low", {31'd0, rsp_valid_o}, 32'd0);
        check("hs_ready_back", {31'd0, cmd_ready_o}, 32'd1);
    endtask

    initial begin
        bit          seen;
        logic [31:0] snap;

        step();
        step();
        check_idle_outputs("reset");
        reset_i = 1'b0;
        step();

        // Write: req pulse with rw=1 in the cycle after accept, no response.
        check("wr_ready_before", {31'd0, cmd_ready_o}, 32'd1);
        send(1'b1, 1'b0, COMM_CONTROL, 32'h0080_0001, '0);
        check("wr_req",   {31'd0, req_o},       32'd1);
        check("wr_rw",    {31'd0, rw_o},        32'd1);
        check("wr_add",   {5'd0, add_o},        {5'd0, COMM_CONTROL});
        check("wr_data",  data_o,               32'h0080_0001);
        check("wr_busy",  {31'd0, busy_o},      32'd1);
        check("wr_ready", {31'd0, cmd_ready_o}, 32'd0);
        step();
        check("wr_req_off",  {31'd0, req_o},       32'd0);
        check("wr_no_rsp",   {31'd0, rsp_valid_o}, 32'd0);
        check("wr_ready_bk", {31'd0, cmd_ready_o}, 32'd1);
        check("wr_hold_add", {5'd0, add_o},        {5'd0, COMM_CONTROL});

        // Read: rsp_valid two cycles after the req cycle, then a 10-cycle response stall.
        mode = 0;
        send(1'b0, 1'b0, COMM_REGISTER1, 32'h0, '0);
        check("rd_req", {31'd0, req_o}, 32'd1);
        check("rd_rw",  {31'd0, rw_o},  32'd0);
        check("rd_add", {5'd0, add_o},  {5'd0, COMM_REGISTER1});
        step();
        check("rd_wait_novalid", {31'd0, rsp_valid_o}, 32'd0);
        step();
        check("rd_valid",   {31'd0, rsp_valid_o},   32'd1);
        check("rd_data",    rsp_data_o,             32'hCAFE_F00D);
        check("rd_timeout", {31'd0, rsp_timeout_o}, 32'd0);
        snap = reqs;
        for (int i = 0; i < 10; i++) begin
            step();
            check("stall_valid", {31'd0, rsp_valid_o}, 32'd1);
            check("stall_data",  rsp_data_o,           32'hCAFE_F00D);
            check("stall_ready", {31'd0, cmd_ready_o}, 32'd0);
            check("stall_noreq", {31'd0, req_o},       32'd0);
        end
        check("stall_req_count", reqs, snap);
        handshake();

        // Poll that matches on the 3rd read: gap = ISSUE + WAIT + 4 GAP cycles.
        mode = 1;
        send(1'b0, 1'b1, COMM_CACHE0, 32'h1, 32'h1);
        check("poll_rw", {31'd0, rw_o}, 32'd0);
        wait_rsp(seen);
        check("poll_seen",    {31'd0, seen},          32'd1);
        check("poll_reads",   nreads,                 32'd3);
        check("poll_gap",     last_gap,               32'd6);
        check("poll_data",    rsp_data_o,             32'hFFFF_FFF1);
        check("poll_timeout", {31'd0, rsp_timeout_o}, 32'd0);
        handshake();

        // Poll that never matches: POLL_MAX reads, timeout flag, last read value returned.
        mode = 2;
        send(1'b0, 1'b1, COMM_CACHE0, 32'h0, 32'h8000_0000);
        wait_rsp(seen);
        check("to_seen",    {31'd0, seen},          32'd1);
        check("to_reads",   nreads,                 32'd8);
        check("to_timeout", {31'd0, rsp_timeout_o}, 32'd1);
        check("to_data",    rsp_data_o,             32'hA5A5_0008);
        handshake();

        // mask=0 matches on the first read.
        send(1'b0, 1'b1, COMM_CACHE0, 32'hFFFF_FFFF, 32'h0);
        wait_rsp(seen);
        check("m0_seen",    {31'd0, seen},          32'd1);
        check("m0_reads",   nreads,                 32'd1);
        check("m0_timeout", {31'd0, rsp_timeout_o}, 32'd0);
        check("m0_data",    rsp_data_o,             32'hA5A5_0001);
        handshake();

        // Reset while in WAIT.
        send(1'b0, 1'b0, COMM_REGISTER1, 32'h0, '0);
        step();
        reset_i = 1'b1;
        step();
        reset_i = 1'b0;
        check_idle_outputs("rst_wait");
        snap = reqs;
        for (int i = 0; i < 8; i++) step();
        check("rst_wait_noreq", reqs, snap);
        check("rst_wait_norsp", {31'd0, rsp_valid_o}, 32'd0);

        // Reset while in GAP (second cycle after the req: WAIT, then first GAP cycle).
        mode = 2;
        send(1'b0, 1'b1, COMM_CACHE0, 32'h0, 32'h8000_0000);
        step();
        step();
        check("gap_busy", {31'd0, busy_o}, 32'd1);
        reset_i = 1'b1;
        step();
        reset_i = 1'b0;
        check_idle_outputs("rst_gap");
        snap = reqs;
        for (int i = 0; i < 12; i++) step();
        check("rst_gap_noreq", reqs, snap);

        check("no_back_to_back", {31'd0, b2b}, 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
